// File: rtl/dadder_pkg.sv
// dadder_pkg
// Shared types and constants for the digit-serial BCD adder/subtracter.
//   dadder_op_e     : operation select (ADD / SUB)
//   dadder_state_e  : sequencing states of dadder_core
//   BCD_DIGIT_W     : bits per packed BCD digit
//   BCD_MAX_DIGIT   : largest legal BCD digit value
//   bcd_nines_comp(): nines' complement of one BCD digit
package dadder_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    DADDER_OP_ADD = 1'b0,
    DADDER_OP_SUB = 1'b1
  } dadder_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } dadder_state_e;

  // Subtraction is done as A + (nines' complement of B) + 1, so the
  // subtrahend digit is mapped to 9-d before entering the digit adder.
  // An illegal digit (>9) wraps mod 16; such operands are flagged
  // invalid and their result is discarded anyway.
  function automatic logic [BCD_DIGIT_W-1:0] bcd_nines_comp(
    input logic [BCD_DIGIT_W-1:0] d
  );
    return BCD_MAX_DIGIT - d;
  endfunction

endpackage

// File: rtl/dadder_if.sv
// dadder_if
// Request/response bundle between the control plane and dadder_core.
//   en, op, a, b                                  : request (master drives)
//   busy, out_valid, result, cout, invalid,
//   err_busy                                      : response (slave drives)
// Modports: master (requester side), slave (dadder_core side).
interface dadder_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int DATA_WIDTH = 4 * NUM_DIGITS;

  logic                  en;
  logic                  op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  cout;
  logic                  invalid;
  logic                  err_busy;

  modport master (
    output en, op, a, b,
    input  busy, out_valid, result, cout, invalid, err_busy
  );

  modport slave (
    input  en, op, a, b,
    output busy, out_valid, result, cout, invalid, err_busy
  );

endinterface

// File: rtl/dadder_digit.sv
// dadder_digit
// Combinational single-digit BCD adder with decimal carry.
//   a_d   : addend digit
//   b_d   : second addend digit (already complemented for SUB)
//   cin   : decimal carry in
//   sum_d : BCD sum digit
//   cout  : decimal carry out
module dadder_digit
  import dadder_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] sum_d,
  output logic                   cout
);

  logic [BCD_DIGIT_W:0] raw;

  // Binary sum first; anything above 9 is pushed past 15 by adding 6 so
  // the low nibble becomes the correct decimal digit and a carry is due.
  always_comb begin
    raw = {1'b0, a_d} + {1'b0, b_d} + {{BCD_DIGIT_W{1'b0}}, cin};
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum_d = raw[BCD_DIGIT_W-1:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      sum_d = raw[BCD_DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/dadder_core.sv
// dadder_core
// Digit-serial BCD adder/subtracter: one decimal digit per clock, least
// significant digit first, result presented with a one-cycle out_valid.
// Ports:
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dadder_if.slave
//             en/op/a/b in; busy/out_valid/result/cout/invalid/err_busy out
// NUM_DIGITS is legal over 1..32.
module dadder_core
  import dadder_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  dadder_if.slave  bus
);

  localparam int DATA_WIDTH = BCD_DIGIT_W * NUM_DIGITS;
  localparam int IDX_W      = $clog2(NUM_DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  dadder_state_e         state;
  dadder_op_e            op_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] result_q;
  logic [IDX_W-1:0]      idx;
  logic                  carry;
  logic                  busy_q;
  logic                  out_valid_q;
  logic                  cout_q;
  logic                  invalid_q;
  logic                  err_busy_q;

  logic [BCD_DIGIT_W-1:0] a_digit;
  logic [BCD_DIGIT_W-1:0] b_digit;
  logic [BCD_DIGIT_W-1:0] b_eff;
  logic [BCD_DIGIT_W-1:0] sum_digit;
  logic                   digit_cout;
  logic                   any_bad;

  // Pick the current digit pair out of the latched operands.
  always_comb begin
    a_digit = '0;
    b_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_digit = a_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        b_digit = b_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  assign b_eff = (op_reg == DADDER_OP_SUB) ? bcd_nines_comp(b_digit) : b_digit;

  dadder_digit u_digit (
    .a_d   (a_digit),
    .b_d   (b_eff),
    .cin   (carry),
    .sum_d (sum_digit),
    .cout  (digit_cout)
  );

  // Operand legality is judged once, on the raw inputs at capture time.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT ||
          bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        any_bad = 1'b1;
      end
    end
  end

  // Sequencer and datapath registers. A capture from DONE is allowed so
  // back-to-back requests lose no cycle; the carry is seeded with op so a
  // SUB becomes A + nines'(B) + 1. idx is wide enough to reach NUM_DIGITS
  // after the last digit, so it never wraps inside a computation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_reg      <= DADDER_OP_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      result_q    <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      invalid_q   <= 1'b0;
      err_busy_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      err_busy_q  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.en) begin
            state     <= CALC;
            busy_q    <= 1'b1;
            op_reg    <= dadder_op_e'(bus.op);
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry     <= bus.op;
            idx       <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            invalid_q <= any_bad;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          err_busy_q <= bus.en;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
              result_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= sum_digit;
            end
          end
          carry <= digit_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            if (invalid_q) begin
              result_q <= '0;
              cout_q   <= 1'b0;
            end else begin
              cout_q <= digit_cout;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.invalid   = invalid_q;
  assign bus.err_busy  = err_busy_q;

endmodule

// File: doc/dadder_core.md
Name: dadder_core

Overview:
- Digit-serial decimal (BCD) adder/subtracter datapath.
- Consumes the control plane strobes `en` (start) and `op` (operation), plus two packed BCD operands.
- Processes one decimal digit per clock, least-significant digit first, then presents a registered result with a one-cycle `out_valid` pulse.
- Sits directly downstream of the control-plane interface and upstream of the result/data-plane monitor.

Parameters:
- NUM_DIGITS, 8, number of BCD digits per operand/result (legal 1..32).
- DATA_WIDTH, 4*NUM_DIGITS, packed operand/result width (derived, not overridden).

Ports:
- clk  input  1  core clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  start strobe; sampled only when not busy.
- op  input  1  operation: 0=ADD (A+B), 1=SUB (A-B).
- a  input  DATA_WIDTH  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  DATA_WIDTH  operand B, packed BCD, same packing.
- busy  output  1  high while digits are being computed.
- out_valid  output  1  one-cycle pulse; result/flags valid.
- result  output  DATA_WIDTH  packed BCD result.
- cout  output  1  ADD: decimal carry out; SUB: 1 = no borrow (A>=B).
- invalid  output  1  an operand nibble was >9 at capture.
- err_busy  output  1  one-cycle pulse: `en` asserted while busy (request dropped).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy, out_valid, cout, invalid, err_busy=0; result=0; digit counter=0.
  - Reset deassertion mid-operation discards the operation; no `out_valid` is produced for it.
- FSM states:
  - IDLE -> CALC on `en`=1.
  - CALC -> DONE after digit NUM_DIGITS-1 is processed.
  - DONE -> CALC if `en`=1, else IDLE.
  - `busy` = (state==CALC), registered.
- Capture (edge T, state IDLE or DONE, en=1):
  - Latch a, b, op.
  - Set carry = op (SUB uses nines'-complement of B with carry-in 1).
  - Set idx=0 and clear result.
  - Set invalid = OR over all 2*NUM_DIGITS nibbles of (nibble>9).
- CALC, one digit per edge:
  - s = A[idx] + (op ? 9-B[idx] : B[idx]) + carry.
  - If s>9: digit = s+6 mod 16, carry=1; else digit = s, carry=0.
  - Write result[idx]; idx++.
- Completion:
  - On the edge processing idx=NUM_DIGITS-1: state->DONE, out_valid=1, cout=final carry.
  - Latency is exactly NUM_DIGITS cycles from the `en` sample edge to `out_valid` high.
- out_valid:
  - High exactly one cycle (state DONE).
  - `result`/`cout`/`invalid` hold their values until the next capture.
- SUB semantics: result = (A - B) mod 10^NUM_DIGITS, i.e. a tens'-complement result when cout=0.
- invalid=1:
  - Computation still runs with the same latency.
  - result is forced to all zeros and cout=0 at completion.
- Overlapping requests:
  - `en`=1 while CALC is ignored; err_busy pulses the following cycle.
  - Back-to-back capture in DONE is legal; `out_valid` and a new capture coincide without loss.
- idx counter: width $clog2(NUM_DIGITS+1); never wraps during CALC, reset to 0 on capture.

Decomposition:
- Package dadder_pkg:
  - dadder_op_e {DADDER_OP_ADD=0, DADDER_OP_SUB=1}.
  - dadder_state_e {IDLE, CALC, DONE}.
  - BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9 constants.
  - Function bcd_nines_comp().
- Sub-module dadder_digit: combinational single-digit BCD add.
  - Inputs: a_d[3:0], b_d[3:0], cin.
  - Outputs: sum_d[3:0], cout.
  - Instantiated once inside dadder_core.

Test Plan:
- ADD, NUM_DIGITS=8: a=0x00001234, b=0x00005678, en pulse -> out_valid exactly 8 cycles later, result=0x00006912, cout=0, invalid=0.
- ADD with carry chain: a=0x99999999, b=0x00000001 -> result=0x00000000, cout=1.
- SUB: a=0x00000500, b=0x00000123 -> result=0x00000377, cout=1. Reversed operands -> result=0x99999623, cout=0.
- Invalid digit: a=0x0000001A, b=0x00000001, ADD -> out_valid after 8 cycles, invalid=1, result=0, cout=0.
- Busy and back-to-back: en at capture, again 3 cycles later -> err_busy single pulse, only one out_valid. Then en held during DONE -> second result follows 8 cycles later with no gap.
- Reset mid-CALC: reset_n low at digit 4 -> all outputs 0 immediately (async). After release, no out_valid until a new en.
